// File: rtl/zap_sram_pkg.sv
// Shared types and helpers for the Wishbone-to-async-SRAM bridge.
// Optional build macro: ZAP_SRAM_BURST_EN enables incrementing-burst continuation.
package zap_sram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACT_LO  = 3'd1,
    ST_TURN_LO = 3'd2,
    ST_ACT_HI  = 3'd3,
    ST_TURN_HI = 3'd4,
    ST_ACK     = 3'd5
  } state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam int unsigned WAIT_STATES_MIN = 1;
  localparam int unsigned WAIT_STATES_MAX = 15;

  // Out-of-range wait-state settings are pinned to the nearest legal value.
  function automatic logic [3:0] clamp_wait(input int unsigned ws);
    int unsigned v;
    if (ws < WAIT_STATES_MIN) begin
      v = WAIT_STATES_MIN;
    end else if (ws > WAIT_STATES_MAX) begin
      v = WAIT_STATES_MAX;
    end else begin
      v = ws;
    end
    return v[3:0];
  endfunction

  function automatic logic [15:0] lane_mask(input logic [1:0] sel);
    return {{8{sel[1]}}, {8{sel[0]}}};
  endfunction

  function automatic state_e first_phase(input logic [3:0] sel);
    state_e s;
    if (sel == 4'b0000) begin
      s = ST_ACK;
    end else if (sel[1:0] != 2'b00) begin
      s = ST_ACT_LO;
    end else begin
      s = ST_ACT_HI;
    end
    return s;
  endfunction

endpackage

// File: rtl/zap_sram_phase_timer.sv
// Loadable 4-bit down-counter; o_last marks the final cycle of an SRAM active phase.
module zap_sram_phase_timer (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  output logic       o_last
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_last = (cnt_q == 4'd1);

endmodule

// File: rtl/zap_wb_sram_ctrl.sv
// Wishbone B3 slave driving a 16-bit asynchronous SRAM, one or two half-word phases per access.
// Optional build macro: ZAP_SRAM_BURST_EN (incrementing-burst continuation from the ACK state).
module zap_wb_sram_ctrl
  import zap_sram_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int WAIT_STATES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wb_cyc,
  input  logic              i_wb_stb,
  input  logic              i_wb_we,
  input  logic [31:0]       i_wb_adr,
  input  logic [3:0]        i_wb_sel,
  input  logic [31:0]       i_wb_dat,
  input  logic [2:0]        i_wb_cti,
  output logic              o_wb_ack,
  output logic [31:0]       o_wb_dat,
  output logic [ADDR_W-1:0] o_sram_adr,
  output logic [15:0]       o_sram_dq,
  input  logic [15:0]       i_sram_dq,
  output logic              o_sram_dq_oe,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n
);

  localparam int         WA_W    = ADDR_W - 1;
  localparam logic [3:0] WS_LOAD = clamp_wait(WAIT_STATES);

  state_e            state_q, state_d;
  logic [WA_W-1:0]   waddr_q, waddr_d;
  logic [3:0]        sel_q, sel_d;
  logic              we_q, we_d;
  logic [31:0]       dat_q, dat_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              abort_q, abort_d;
`ifdef ZAP_SRAM_BURST_EN
  logic [2:0]        cti_q, cti_d;
`endif

  logic              wb_ack_q, wb_ack_d;
  logic [31:0]       wb_dat_q, wb_dat_d;
  logic [ADDR_W-1:0] sram_adr_q, sram_adr_d;
  logic [15:0]       sram_dq_q, sram_dq_d;
  logic              sram_dq_oe_q, sram_dq_oe_d;
  logic              sram_ce_n_q, sram_ce_n_d;
  logic              sram_oe_n_q, sram_oe_n_d;
  logic              sram_we_n_q, sram_we_n_d;
  logic              sram_lb_n_q, sram_lb_n_d;
  logic              sram_ub_n_q, sram_ub_n_d;

  logic phase_last, timer_load, act_s, busy_s, hi_s;

  zap_sram_phase_timer u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (timer_load),
    .i_load_val (WS_LOAD),
    .o_last     (phase_last)
  );

  // Next-state and transaction latch logic
  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    sel_d   = sel_q;
    we_d    = we_q;
    dat_d   = dat_q;
    rdata_d = rdata_q;
    abort_d = abort_q;
`ifdef ZAP_SRAM_BURST_EN
    cti_d   = cti_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_wb_cyc && i_wb_stb) begin
          waddr_d = i_wb_adr[ADDR_W:2];
          sel_d   = i_wb_sel;
          we_d    = i_wb_we;
          dat_d   = i_wb_dat;
          rdata_d = 32'h0000_0000;
          abort_d = 1'b0;
`ifdef ZAP_SRAM_BURST_EN
          cti_d   = i_wb_cti;
`endif
          state_d = first_phase(i_wb_sel);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACT_LO: begin
        abort_d = abort_q | ~i_wb_cyc;
        if (phase_last) begin
          if (!we_q) begin
            rdata_d[15:0] = lane_mask(sel_q[1:0]) & i_sram_dq;
          end else begin
            rdata_d = rdata_q;
          end
          state_d = ST_TURN_LO;
        end else begin
          state_d = ST_ACT_LO;
        end
      end
      ST_TURN_LO: begin
        if (abort_q || !i_wb_cyc) begin
          state_d = ST_IDLE;
        end else if (sel_q[3:2] != 2'b00) begin
          state_d = ST_ACT_HI;
        end else begin
          state_d = ST_ACK;
        end
      end
      ST_ACT_HI: begin
        abort_d = abort_q | ~i_wb_cyc;
        if (phase_last) begin
          if (!we_q) begin
            rdata_d[31:16] = lane_mask(sel_q[3:2]) & i_sram_dq;
          end else begin
            rdata_d = rdata_q;
          end
          state_d = ST_TURN_HI;
        end else begin
          state_d = ST_ACT_HI;
        end
      end
      ST_TURN_HI: begin
        if (abort_q || !i_wb_cyc) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
`ifdef ZAP_SRAM_BURST_EN
        // Burst beats advance the word address internally; i_wb_adr is not re-read.
        if ((cti_q == CTI_INCR) && i_wb_cyc && i_wb_stb) begin
          waddr_d = waddr_q + {{(WA_W-1){1'b0}}, 1'b1};
          sel_d   = i_wb_sel;
          we_d    = i_wb_we;
          dat_d   = i_wb_dat;
          cti_d   = i_wb_cti;
          rdata_d = 32'h0000_0000;
          abort_d = 1'b0;
          state_d = first_phase(i_wb_sel);
        end else begin
          state_d = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values derived from the upcoming state so every pin comes straight from a flop
  always_comb begin
    act_s      = (state_d == ST_ACT_LO) || (state_d == ST_ACT_HI);
    busy_s     = act_s || (state_d == ST_TURN_LO) || (state_d == ST_TURN_HI);
    hi_s       = (state_d == ST_ACT_HI) || (state_d == ST_TURN_HI);
    timer_load = act_s && (state_d != state_q);

    wb_ack_d     = (state_d == ST_ACK);
    sram_ce_n_d  = ~busy_s;
    sram_we_n_d  = ~(act_s && we_d);
    sram_oe_n_d  = ~(act_s && !we_d);
    sram_dq_oe_d = busy_s && we_d;

    if (wb_ack_d) begin
      wb_dat_d = rdata_d;
    end else begin
      wb_dat_d = wb_dat_q;
    end

    if (busy_s) begin
      sram_adr_d  = {waddr_d, hi_s};
      sram_lb_n_d = hi_s ? ~sel_d[2] : ~sel_d[0];
      sram_ub_n_d = hi_s ? ~sel_d[3] : ~sel_d[1];
      if (we_d) begin
        sram_dq_d = hi_s ? dat_d[31:16] : dat_d[15:0];
      end else begin
        sram_dq_d = sram_dq_q;
      end
    end else begin
      sram_adr_d  = sram_adr_q;
      sram_lb_n_d = 1'b1;
      sram_ub_n_d = 1'b1;
      sram_dq_d   = sram_dq_q;
    end
  end

  // State, transaction and output registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      waddr_q      <= '0;
      sel_q        <= 4'b0000;
      we_q         <= 1'b0;
      dat_q        <= 32'h0000_0000;
      rdata_q      <= 32'h0000_0000;
      abort_q      <= 1'b0;
`ifdef ZAP_SRAM_BURST_EN
      cti_q        <= CTI_CLASSIC;
`endif
      wb_ack_q     <= 1'b0;
      wb_dat_q     <= 32'h0000_0000;
      sram_adr_q   <= '0;
      sram_dq_q    <= 16'h0000;
      sram_dq_oe_q <= 1'b0;
      sram_ce_n_q  <= 1'b1;
      sram_oe_n_q  <= 1'b1;
      sram_we_n_q  <= 1'b1;
      sram_lb_n_q  <= 1'b1;
      sram_ub_n_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      waddr_q      <= waddr_d;
      sel_q        <= sel_d;
      we_q         <= we_d;
      dat_q        <= dat_d;
      rdata_q      <= rdata_d;
      abort_q      <= abort_d;
`ifdef ZAP_SRAM_BURST_EN
      cti_q        <= cti_d;
`endif
      wb_ack_q     <= wb_ack_d;
      wb_dat_q     <= wb_dat_d;
      sram_adr_q   <= sram_adr_d;
      sram_dq_q    <= sram_dq_d;
      sram_dq_oe_q <= sram_dq_oe_d;
      sram_ce_n_q  <= sram_ce_n_d;
      sram_oe_n_q  <= sram_oe_n_d;
      sram_we_n_q  <= sram_we_n_d;
      sram_lb_n_q  <= sram_lb_n_d;
      sram_ub_n_q  <= sram_ub_n_d;
    end
  end

  assign o_wb_ack     = wb_ack_q;
  assign o_wb_dat     = wb_dat_q;
  assign o_sram_adr   = sram_adr_q;
  assign o_sram_dq    = sram_dq_q;
  assign o_sram_dq_oe = sram_dq_oe_q;
  assign o_sram_ce_n  = sram_ce_n_q;
  assign o_sram_oe_n  = sram_oe_n_q;
  assign o_sram_we_n  = sram_we_n_q;
  assign o_sram_lb_n  = sram_lb_n_q;
  assign o_sram_ub_n  = sram_ub_n_q;

  // Byte-offset and out-of-window address bits carry no meaning here
  logic unused_ok;
`ifdef ZAP_SRAM_BURST_EN
  assign unused_ok = ^{i_wb_adr[1:0], i_wb_adr[31:ADDR_W+1]};
`else
  assign unused_ok = ^{i_wb_adr[1:0], i_wb_adr[31:ADDR_W+1], i_wb_cti};
`endif

endmodule

// File: tb/tb_zap_wb_sram_ctrl.sv
// Self-checking bench for zap_wb_sram_ctrl: behavioural SRAM model, vector table and scoreboard.
module tb_zap_wb_sram_ctrl;
  import zap_sram_pkg::*;

  localparam int ADDR_W   = 20;
  localparam int WS       = 2;
  localparam int FULL_LAT = 2 * (WS + 1) + 1;
  localparam int HALF_LAT = WS + 2;
`ifdef ZAP_SRAM_BURST_EN
  localparam int BEAT_GAP = 2 * (WS + 1) + 1;
`else
  localparam int BEAT_GAP = 2 * (WS + 1) + 2;
`endif

  logic              clk, rst_n;
  logic              cyc, stb, we;
  logic [31:0]       adr, dat;
  logic [3:0]        sel;
  logic [2:0]        cti;
  logic              o_wb_ack;
  logic [31:0]       o_wb_dat;
  logic [ADDR_W-1:0] o_sram_adr;
  logic [15:0]       o_sram_dq, i_sram_dq;
  logic              o_sram_dq_oe, o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n;

  zap_wb_sram_ctrl #(.ADDR_W(ADDR_W), .WAIT_STATES(WS)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_adr(adr),
    .i_wb_sel(sel), .i_wb_dat(dat), .i_wb_cti(cti),
    .o_wb_ack(o_wb_ack), .o_wb_dat(o_wb_dat),
    .o_sram_adr(o_sram_adr), .o_sram_dq(o_sram_dq), .i_sram_dq(i_sram_dq),
    .o_sram_dq_oe(o_sram_dq_oe), .o_sram_ce_n(o_sram_ce_n), .o_sram_oe_n(o_sram_oe_n),
    .o_sram_we_n(o_sram_we_n), .o_sram_lb_n(o_sram_lb_n), .o_sram_ub_n(o_sram_ub_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM model: 1K half-words, combinational read, byte-lane writes sampled on the falling edge
  bit   [15:0] mem [0:1023];
  logic [9:0]  midx;
  logic        act_now;
  bit          act_prev;
  bit          preloaded;
  int          we_run;
  logic [21:0] acc_log [$];
  int          we_runs [$];

  assign midx      = o_sram_adr[9:0];
  assign act_now   = !o_sram_ce_n && (!o_sram_we_n || !o_sram_oe_n);
  assign i_sram_dq = (!o_sram_ce_n && !o_sram_oe_n) ? mem[midx] : 16'h0000;

  always @(negedge clk) begin
    if (!preloaded) begin
      mem[10'h080] <= 16'h1234;
      mem[10'h081] <= 16'h5678;
      for (int i = 0; i < 8; i++) mem[10'h100 + i] <= 16'hA000 + 16'(i);
      preloaded <= 1'b1;
    end else begin
      if (!o_sram_ce_n && !o_sram_we_n) begin
        if (!o_sram_lb_n) mem[midx][7:0]  <= o_sram_dq[7:0];
        if (!o_sram_ub_n) mem[midx][15:8] <= o_sram_dq[15:8];
      end
      if (act_now && !act_prev) acc_log.push_back({o_sram_ub_n, o_sram_lb_n, o_sram_adr});
      act_prev <= act_now;
      if (!o_sram_we_n) begin
        we_run <= we_run + 1;
      end else if (we_run != 0) begin
        we_runs.push_back(we_run);
        we_run <= 0;
      end
    end
  end

  typedef struct {
    logic        chk_dat;
    logic [31:0] exp_dat;
    int          exp_lat;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] exp_dat;
    int          exp_lat;
  } vec_t;

  exp_t sb [$];
  vec_t vecs [12];
  int   n_cmp, n_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    adr = 32'h0; dat = 32'h0; cti = CTI_CLASSIC;
  endtask

  task automatic count_acks(input string name, input int cycles);
    int acks;
    acks = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (o_wb_ack) acks++;
    end
    check(name, 64'(acks), 64'd0);
  endtask

  // One single-beat access; expectation queued at drive time, checked when ack appears
  task automatic access(input string name, input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input logic chk, input logic [31:0] exp_d, input int exp_lat);
    exp_t e;
    int   t;
    bit   got;
    e.chk_dat = chk; e.exp_dat = exp_d; e.exp_lat = exp_lat;
    sb.push_back(e);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d; cti = CTI_CLASSIC;
    t = 0; got = 1'b0;
    while (!got && t < 40) begin
      tick();
      t++;
      if (o_wb_ack) begin
        got = 1'b1;
        e = sb.pop_front();
        check({name, " latency"}, 64'(t), 64'(e.exp_lat));
        if (e.chk_dat) check({name, " data"}, 64'(o_wb_dat), 64'(e.exp_dat));
        check({name, " strobes idle"}, {61'd0, o_sram_ce_n, o_sram_oe_n, o_sram_we_n}, {61'd0, 3'b111});
        drive_idle();
      end
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL %s: no ack within 40 cycles", name);
      e = sb.pop_front();
      drive_idle();
    end
    tick();
    check({name, " ack single cycle"}, 64'(o_wb_ack), 64'd0);
  endtask

  initial begin
    int   base_a, base_w, t, k, last_t;
    exp_t e;
    n_cmp = 0; n_err = 0;

    vecs[0]  = '{1'b0, 32'h0000_0100, 4'b1111, 32'h0,          32'hDEAA_BEEF, FULL_LAT};
    vecs[1]  = '{1'b0, 32'h0000_0100, 4'b0011, 32'h0,          32'h0000_BEEF, HALF_LAT};
    vecs[2]  = '{1'b0, 32'h0000_0100, 4'b1000, 32'h0,          32'hDE00_0000, HALF_LAT};
    vecs[3]  = '{1'b0, 32'h0000_0100, 4'b0110, 32'h0,          32'h00AA_BE00, FULL_LAT};
    vecs[4]  = '{1'b0, 32'h0000_0100, 4'b0000, 32'h0,          32'h0000_0000, 1};
    vecs[5]  = '{1'b1, 32'h0000_0104, 4'b0000, 32'hFFFF_FFFF,  32'h0,         1};
    vecs[6]  = '{1'b0, 32'h0000_0104, 4'b1111, 32'h0,          32'h0000_0000, FULL_LAT};
    vecs[7]  = '{1'b1, 32'h003F_FFFC, 4'b1111, 32'hCAFE_F00D,  32'h0,         FULL_LAT};
    vecs[8]  = '{1'b0, 32'h003F_FFFC, 4'b1111, 32'h0,          32'hCAFE_F00D, FULL_LAT};
    vecs[9]  = '{1'b0, 32'h0020_0100, 4'b1111, 32'h0,          32'hDEAA_BEEF, FULL_LAT};
    vecs[10] = '{1'b1, 32'h0000_0108, 4'b0001, 32'h1234_5678,  32'h0,         HALF_LAT};
    vecs[11] = '{1'b0, 32'h0000_0108, 4'b1111, 32'h0,          32'h0000_0078, FULL_LAT};

    // Reset under random bus activity
    rst_n = 1'b0;
    cyc = 1'($urandom_range(0, 1)); stb = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
    adr = $urandom; dat = $urandom; sel = 4'($urandom); cti = 3'($urandom);
    for (int i = 0; i < 3; i++) begin
      tick();
      cyc = 1'($urandom_range(0, 1)); stb = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
      adr = $urandom; dat = $urandom; sel = 4'($urandom); cti = 3'($urandom);
    end
    check("reset wb outputs", {31'd0, o_wb_ack, o_wb_dat}, 64'd0);
    check("reset sram outputs",
          {22'd0, o_sram_adr, o_sram_dq, o_sram_dq_oe, o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n},
          {22'd0, 20'd0, 16'd0, 1'b0, 5'b11111});
    drive_idle();
    rst_n = 1'b1;
    count_acks("no ack after reset", 6);

    access("read word", 1'b0, 32'h100, 4'b1111, 32'h0, 1'b1, 32'h5678_1234, FULL_LAT);

    base_a = acc_log.size(); base_w = we_runs.size();
    access("write word", 1'b1, 32'h100, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0, FULL_LAT);
    check("write word lo", 64'(mem[10'h080]), 64'h0000_BEEF);
    check("write word hi", 64'(mem[10'h081]), 64'h0000_DEAD);
    check("write word phases", 64'(acc_log.size() - base_a), 64'd2);
    check("write word adr lo", 64'(acc_log[base_a]), {42'd0, 2'b00, 20'h00080});
    check("write word adr hi", 64'(acc_log[base_a + 1]), {42'd0, 2'b00, 20'h00081});
    check("write word we runs", 64'(we_runs.size() - base_w), 64'd2);
    check("write word we_n lo", 64'(we_runs[base_w]), 64'(WS));
    check("write word we_n hi", 64'(we_runs[base_w + 1]), 64'(WS));

    base_a = acc_log.size();
    access("byte write", 1'b1, 32'h100, 4'b0100, 32'h00AA_0000, 1'b0, 32'h0, HALF_LAT);
    check("byte write phases", 64'(acc_log.size() - base_a), 64'd1);
    check("byte write adr lanes", 64'(acc_log[base_a]), {42'd0, 2'b10, 20'h00081});
    check("byte write data", 64'(mem[10'h081]), 64'h0000_DEAA);
    check("byte write lo untouched", 64'(mem[10'h080]), 64'h0000_BEEF);

    for (int i = 0; i < 12; i++) begin
      access($sformatf("vec%0d", i), vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat,
             !vecs[i].we, vecs[i].exp_dat, vecs[i].exp_lat);
    end
    check("sel0 write no access", {32'd0, mem[10'h082], mem[10'h083]}, 64'd0);

    // Four-beat incrementing read burst from 0x200
    base_a = acc_log.size();
    for (int j = 0; j < 4; j++) begin
      e.chk_dat = 1'b1;
      e.exp_dat = {16'hA000 + 16'(2 * j + 1), 16'hA000 + 16'(2 * j)};
      e.exp_lat = 0;
      sb.push_back(e);
    end
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'b1111; adr = 32'h200; dat = 32'h0; cti = CTI_INCR;
    t = 0; k = 0; last_t = 0;
    while (k < 4 && t < 200) begin
      tick();
      t++;
      if (o_wb_ack) begin
        e = sb.pop_front();
        check($sformatf("burst beat%0d data", k), 64'(o_wb_dat), 64'(e.exp_dat));
        if (k == 0) check("burst first ack", 64'(t), 64'(FULL_LAT));
        else check($sformatf("burst beat%0d spacing", k), 64'(t - last_t), 64'(BEAT_GAP));
        last_t = t;
        k++;
        if (k == 4) begin
          drive_idle();
        end else begin
          adr = 32'h200 + 32'(4 * k);
          cti = (k == 3) ? CTI_EOB : CTI_INCR;
        end
      end
    end
    if (k < 4) begin
      n_cmp++; n_err++;
      $display("FAIL burst: only %0d of 4 acks within 200 cycles", k);
      drive_idle();
      while (sb.size() > 0) e = sb.pop_front();
    end
    count_acks("burst no extra ack", 12);
    check("burst phases", 64'(acc_log.size() - base_a), 64'd8);
    for (int j = 0; j < 8; j++) begin
      check($sformatf("burst adr%0d", j), 64'(acc_log[base_a + j][19:0]), 64'(20'h00100 + 20'(j)));
    end

    // Cycle dropped during the first active phase of a write
    base_a = acc_log.size();
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'b1111; adr = 32'h300; dat = 32'h1111_2222; cti = CTI_CLASSIC;
    tick();
    drive_idle();
    count_acks("abort no ack", 12);
    check("abort phases", 64'(acc_log.size() - base_a), 64'd1);
    check("abort lo written", 64'(mem[10'h180]), 64'h0000_2222);
    check("abort hi untouched", 64'(mem[10'h181]), 64'h0000_0000);

    // Reset asserted during the high-half active phase of a write
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'b1111; adr = 32'h300; dat = 32'h3333_4444; cti = CTI_CLASSIC;
    for (int i = 0; i < 4; i++) tick();
    check("act_hi before reset", {43'd0, o_sram_we_n, o_sram_adr}, {43'd0, 1'b0, 20'h00181});
    rst_n = 1'b0;
    tick();
    check("reset in act_hi", {60'd0, o_sram_we_n, o_sram_ce_n, o_sram_dq_oe, o_wb_ack}, {60'd0, 4'b1100});
    rst_n = 1'b1;
    drive_idle();
    count_acks("reset in act_hi no ack", 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
